alu_issue_ctrl: RTL and testbench

- Initiator/sequencer side of the 8-bit ALU interface. It accepts 9-bit register-to-register instructions over a valid/ready handshake and reads operands from an internal 4x8 register file.
- It drives the ALU select, opcode and operand lines with a fixed setup/execute/capture timing, then writes the ALU result back to the destination register.
- Sits between the instruction source and the combinational ALU; it is the only driver of the ALU's input side.

---
 rtl/alu_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit combinational ALU: accepts register-to-register
// instructions, sequences the ALU through setup/execute/writeback, owns the register file.
module alu_issue_ctrl #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8:0]        in_instr,
    input  logic [DATA_W-1:0] in_imm,
    output logic              alu_sel,
    output logic [2:0]        alu_order,
    output logic [DATA_W-1:0] reg_1,
    output logic [DATA_W-1:0] reg_2,
    input  logic [DATA_W-1:0] alu_out,
    output logic              done,
    output logic [1:0]        done_rd,
    output logic [DATA_W-1:0] done_data,
    output logic              zero,
    output logic              err,
    input  logic [1:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {IDLE, SETUP, EXEC, WB} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [1:0]        rd_q;
    logic              ldi_q;
    logic [2:0]        order_q;
    logic [DATA_W-1:0] opa_q, opb_q;
    logic              done_q, zero_q, err_q;
    logic [1:0]        done_rd_q;
    logic [DATA_W-1:0] done_data_q;

    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic       accept;

    assign op  = in_instr[8:6];
    assign rd  = in_instr[5:4];
    assign rs1 = in_instr[3:2];
    assign rs2 = in_instr[1:0];

    assign in_ready = (state_q == IDLE) && rst_n;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op == OP_LDI) begin
                        state_d = WB;
                    end else if (op != OP_ILL) begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP:   state_d = EXEC;
            EXEC:    state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are captured at acceptance and the ALU result is captured on the
    // EXEC->WB edge, so the write and the done pulse both land in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
            rd_q        <= '0;
            ldi_q       <= 1'b0;
            order_q     <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            done_q      <= 1'b0;
            done_rd_q   <= '0;
            done_data_q <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                case (op)
                    OP_LDI: begin
                        rf_q[rd]    <= in_imm;
                        ldi_q       <= 1'b1;
                        done_q      <= 1'b1;
                        done_rd_q   <= rd;
                        done_data_q <= in_imm;
                        zero_q      <= (in_imm == '0);
                    end
                    OP_ILL: begin
                        err_q <= 1'b1;
                    end
                    default: begin
                        ldi_q   <= 1'b0;
                        rd_q    <= rd;
                        order_q <= op;
                        opa_q   <= rf_q[rs1];
                        opb_q   <= rf_q[rs2];
                    end
                endcase
            end
            if (state_q == EXEC) begin
                rf_q[rd_q]  <= alu_out;
                done_q      <= 1'b1;
                done_rd_q   <= rd_q;
                done_data_q <= alu_out;
                zero_q      <= (alu_out == '0);
            end
        end
    end

    assign alu_sel   = (state_q == EXEC) || ((state_q == WB) && !ldi_q);
    assign alu_order = order_q;
    assign reg_1     = opa_q;
    assign reg_2     = opb_q;
    assign done      = done_q;
    assign done_rd   = done_rd_q;
    assign done_data = done_data_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign dbg_data  = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU and a result scoreboard;
// all sampling happens on the falling clock edge.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_instr = '0;
    logic [7:0] in_imm = '0;
    logic       alu_sel;
    logic [2:0] alu_order;
    logic [7:0] reg_1, reg_2;
    wire  [7:0] alu_out;
    logic       done;
    logic [1:0] done_rd;
    logic [7:0] done_data;
    logic       zero;
    logic       err;
    logic [1:0] dbg_addr = '0;
    logic [7:0] dbg_data;

    typedef struct packed {
        logic [1:0] rd;
        logic [7:0] data;
    } exp_t;

    exp_t       sbQ[$];
    logic [7:0] refRf [4];
    logic [7:0] lastData;
    int         total = 0;
    int         passed = 0;
    int         failed = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(8), .NREG(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_imm(in_imm), .alu_sel(alu_sel), .alu_order(alu_order),
        .reg_1(reg_1), .reg_2(reg_2), .alu_out(alu_out), .done(done), .done_rd(done_rd),
        .done_data(done_data), .zero(zero), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    function automatic logic [7:0] aluRef(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a | b;
            3'd1:    return ~(a & b);
            3'd2:    return ~(a | b);
            3'd3:    return a & b;
            3'd4:    return a + b;
            3'd5:    return a - b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_out = alu_sel ? aluRef(alu_order, reg_1, reg_2) : 8'hzz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Presents one instruction, waits for its acceptance edge and records the expected result.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                 input logic [1:0] rs2, input logic [7:0] imm);
        exp_t e;
        int   w;
        @(negedge clk);
        in_instr = {op, rd, rs1, rs2};
        in_imm   = imm;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", in_ready, 1);
        if (op != 3'b111) begin
            e.rd   = rd;
            e.data = (op == 3'b110) ? imm : aluRef(op, refRf[rs1], refRf[rs2]);
            refRf[rd] = e.data;
            sbQ.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called on the first falling edge after acceptance; expLat counts from that edge as 1.
    task automatic checkOutput(input string tag, input bit isAlu, input int expLat);
        int         lat;
        exp_t       e;
        logic [2:0] ord;
        ord = in_instr[8:6];
        lat = 1;
        while (!done && lat < 12) begin
            check({tag, "_ready_low"}, in_ready, 0);
            if (isAlu) begin
                check({tag, "_sel"}, alu_sel, (lat == 1) ? 0 : 1);
                check({tag, "_order"}, alu_order, ord);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, expLat);
        if (isAlu) begin
            check({tag, "_sel_wb"}, alu_sel, 1);
        end
        if (sbQ.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sbQ.pop_front();
            lastData = done_data;
            check({tag, "_rd"}, done_rd, e.rd);
            check({tag, "_data"}, done_data, e.data);
            check({tag, "_zero"}, zero, (e.data == 8'h00));
            dbg_addr = e.rd;
            #1;
            check({tag, "_dbg"}, dbg_data, e.data);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_sel_idle"}, alu_sel, 0);
    endtask

    initial begin
        int   acc;
        int   lowRun;
        int   cyc;
        exp_t e;
        logic zeroBefore;

        for (int i = 0; i < 4; i++) refRf[i] = 8'h00;
        $display("[TB] reset phase");
        repeat (2) @(negedge clk);
        check("rst_ready", in_ready, 0);
        check("rst_sel", alu_sel, 0);
        check("rst_order", alu_order, 0);
        check("rst_reg1", reg_1, 0);
        check("rst_done", done, 0);
        check("rst_zero", zero, 0);
        check("rst_err", err, 0);
        check("rst_dbg", dbg_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", in_ready, 1);

        applyStimulus(3'b110, 2'd1, 2'd0, 2'd0, 8'h0F);
        checkOutput("ldi_r1", 0, 1);
        applyStimulus(3'b110, 2'd2, 2'd0, 2'd0, 8'hF0);
        checkOutput("ldi_r2", 0, 1);
        applyStimulus(3'b100, 2'd3, 2'd1, 2'd2, 8'h00);
        checkOutput("add_r3", 1, 3);
        check("add_const", lastData, 8'hFF);

        applyStimulus(3'b110, 2'd1, 2'd0, 2'd0, 8'h01);
        checkOutput("ldi_1", 0, 1);
        applyStimulus(3'b110, 2'd2, 2'd0, 2'd0, 8'h02);
        checkOutput("ldi_2", 0, 1);
        applyStimulus(3'b101, 2'd0, 2'd1, 2'd2, 8'h00);
        checkOutput("sub_wrap", 1, 3);
        check("sub_wrap_const", lastData, 8'hFF);
        applyStimulus(3'b101, 2'd0, 2'd1, 2'd1, 8'h00);
        checkOutput("sub_zero", 1, 3);
        check("sub_zero_flag", zero, 1);

        applyStimulus(3'b110, 2'd1, 2'd0, 2'd0, 8'hAA);
        checkOutput("ldi_aa", 0, 1);
        applyStimulus(3'b110, 2'd2, 2'd0, 2'd0, 8'h0F);
        checkOutput("ldi_0f", 0, 1);
        for (int op = 0; op < 6; op++) begin
            applyStimulus(3'(op), 2'd3, 2'd1, 2'd2, 8'h00);
            checkOutput($sformatf("sweep_op%0d", op), 1, 3);
        end
        check("sweep_sub_const", lastData, 8'h9B);

        zeroBefore = zero;
        applyStimulus(3'b111, 2'd3, 2'd1, 2'd2, 8'h00);
        check("ill_err", err, 1);
        check("ill_done", done, 0);
        check("ill_ready", in_ready, 1);
        @(negedge clk);
        check("ill_err_pulse", err, 0);
        check("ill_zero", zero, zeroBefore);
        dbg_addr = 2'd3;
        #1;
        check("ill_rf", dbg_data, refRf[3]);

        applyStimulus(3'b110, 2'd1, 2'd0, 2'd0, 8'h01);
        checkOutput("ldi_chain", 0, 1);
        in_instr = {3'b100, 2'd1, 2'd1, 2'd1};
        in_valid = 1'b1;
        acc = 0;
        lowRun = 0;
        cyc = 0;
        while ((acc < 4 || sbQ.size() > 0) && cyc < 60) begin
            if (acc == 4) in_valid = 1'b0;
            if (in_valid && in_ready) begin
                if (acc > 0) check("b2b_gap", lowRun, 3);
                e.rd = 2'd1;
                e.data = aluRef(3'b100, refRf[1], refRf[1]);
                refRf[1] = e.data;
                sbQ.push_back(e);
                acc++;
                lowRun = 0;
            end else if (in_valid) begin
                lowRun++;
            end
            if (done) begin
                e = sbQ.pop_front();
                check("b2b_data", done_data, e.data);
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_timeout", cyc < 60, 1);
        check("b2b_accepts", acc, 4);
        dbg_addr = 2'd1;
        #1;
        check("b2b_final", dbg_data, 8'h10);

        applyStimulus(3'b110, 2'd2, 2'd0, 2'd0, 8'h05);
        checkOutput("ldi_rst", 0, 1);
        applyStimulus(3'b100, 2'd3, 2'd1, 2'd2, 8'h00);
        @(negedge clk);
        check("mid_exec_sel", alu_sel, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sel", alu_sel, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        check("mid_rst_done2", done, 0);
        rst_n = 1'b1;
        sbQ.delete();
        for (int i = 0; i < 4; i++) refRf[i] = 8'h00;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
        check("post_rst_done", done, 0);
        dbg_addr = 2'd3;
        #1;
        check("post_rst_r3", dbg_data, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
